// File: rtl/ccs_seq_ctl_if.sv
// CCS sequencer host/switch-stage signal bundle: config write, emission control and active settings.
// master = host/bench side, slave = sequencer side.
interface ccs_seq_ctl_if;
    logic        cfg_wr_i;
    logic [1:0]  cfg_mode_i;
    logic [20:0] cfg_period_i;
    logic [20:0] cfg_duty_i;
    logic [7:0]  cfg_fpul_i;
    logic        cfg_ack_o;
    logic        cfg_err_o;
    logic        emit_req_i;
    logic        interlock_ok_i;
    logic        fault_i;
    logic        fault_clr_i;
    logic        enable_o;
    logic        ccs_rd_o;
    logic [1:0]  mode_sel_o;
    logic [20:0] period_count_o;
    logic [20:0] duty_count_o;
    logic [7:0]  fpul_dep_delay_o;
    logic [2:0]  state_o;

    modport master (
        output cfg_wr_i, cfg_mode_i, cfg_period_i, cfg_duty_i, cfg_fpul_i,
        output emit_req_i, interlock_ok_i, fault_i, fault_clr_i,
        input  cfg_ack_o, cfg_err_o, enable_o, ccs_rd_o, mode_sel_o,
        input  period_count_o, duty_count_o, fpul_dep_delay_o, state_o
    );

    modport slave (
        input  cfg_wr_i, cfg_mode_i, cfg_period_i, cfg_duty_i, cfg_fpul_i,
        input  emit_req_i, interlock_ok_i, fault_i, fault_clr_i,
        output cfg_ack_o, cfg_err_o, enable_o, ccs_rd_o, mode_sel_o,
        output period_count_o, duty_count_o, fpul_dep_delay_o, state_o
    );
endinterface

// File: rtl/ccs_seq_ctl.sv
// Purpose: CCS lightout sequencer (IDLE/ARM/EMIT/STOP/FAULT) plus validated config shadow; CCS_SOFTSTART_EN adds EMIT duty ramp in mode 11.
// Latency: enable 1 edge after request, ccs_rd ARM_DLY edges later; config ack/err and data 1 edge after write.
// Backpressure: none; every config write gets exactly one ack or err pulse, writes may be back-to-back.
module ccs_seq_ctl #(
    parameter int unsigned ARM_DLY    = 64000,
    parameter int unsigned STOP_DLY   = 6400,
    parameter int unsigned PERIOD_MIN = 1280,
    parameter int unsigned PERIOD_MAX = 1280000
`ifdef CCS_SOFTSTART_EN
    ,
    parameter int unsigned RAMP_STEP  = 64,
    parameter int unsigned RAMP_TICK  = 640
`endif
) (
    input  logic          clk64_i,
    input  logic          rstn_i,
    ccs_seq_ctl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_EMIT  = 3'd2,
        S_STOP  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [23:0] timer;
    logic        enable;
    logic        ccs_rd;

    logic        cfg_ok;
    logic        ack;
    logic        err;
    logic [1:0]  mode_sel;
    logic [1:0]  mode_pend;
    logic        mode_pend_vld;
    logic [20:0] period_sh;
    logic [20:0] duty_sh;
    logic [7:0]  fpul_sh;

    always_comb begin
        state_nxt = state;
        // Fault and interlock loss pre-empt every other transition.
        if ((state != S_FAULT) && (bus.fault_i || !bus.interlock_ok_i)) begin
            state_nxt = S_FAULT;
        end else begin
            case (state)
                S_IDLE:  if (bus.emit_req_i) state_nxt = S_ARM;
                S_ARM: begin
                    if (!bus.emit_req_i)     state_nxt = S_IDLE;
                    else if (timer == '0)    state_nxt = S_EMIT;
                end
                S_EMIT:  if (!bus.emit_req_i) state_nxt = S_STOP;
                S_STOP:  if (timer == '0)     state_nxt = S_IDLE;
                S_FAULT: begin
                    if (bus.fault_clr_i && !bus.fault_i && bus.interlock_ok_i && !bus.emit_req_i)
                        state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk64_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state  <= S_IDLE;
            enable <= 1'b0;
            ccs_rd <= 1'b0;
            timer  <= '0;
        end else begin
            state  <= state_nxt;
            enable <= (state_nxt == S_ARM) || (state_nxt == S_EMIT) || (state_nxt == S_STOP);
            ccs_rd <= (state_nxt == S_EMIT);
            if ((state == S_IDLE) && (state_nxt == S_ARM))
                timer <= 24'(ARM_DLY - 1);
            else if ((state == S_EMIT) && (state_nxt == S_STOP))
                timer <= 24'(STOP_DLY - 1);
            else if (state_nxt != state)
                timer <= '0;
            else if (timer != '0)
                timer <= timer - 24'd1;
        end
    end

    always_comb begin
        cfg_ok = 1'b1;
        if (bus.cfg_mode_i != 2'b00) begin
            cfg_ok = (bus.cfg_period_i >= 21'(PERIOD_MIN)) &&
                     (bus.cfg_period_i <= 21'(PERIOD_MAX)) &&
                     (bus.cfg_duty_i   <= bus.cfg_period_i);
        end
    end

    always_ff @(posedge clk64_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ack           <= 1'b0;
            err           <= 1'b0;
            period_sh     <= '0;
            duty_sh       <= '0;
            fpul_sh       <= '0;
            mode_sel      <= '0;
            mode_pend     <= '0;
            mode_pend_vld <= 1'b0;
        end else begin
            ack <= bus.cfg_wr_i && cfg_ok;
            err <= bus.cfg_wr_i && !cfg_ok;
            if (bus.cfg_wr_i && cfg_ok) begin
                period_sh <= bus.cfg_period_i;
                duty_sh   <= bus.cfg_duty_i;
                fpul_sh   <= bus.cfg_fpul_i;
            end
            // Mode only changes while idle; a write landing on the IDLE entry edge beats the pending one.
            if (bus.cfg_wr_i && cfg_ok && ((state == S_IDLE) || (state_nxt == S_IDLE))) begin
                mode_sel      <= bus.cfg_mode_i;
                mode_pend_vld <= 1'b0;
            end else begin
                if (bus.cfg_wr_i && cfg_ok) begin
                    mode_pend     <= bus.cfg_mode_i;
                    mode_pend_vld <= 1'b1;
                end
                if (mode_pend_vld && (state_nxt == S_IDLE)) begin
                    mode_sel      <= mode_pend;
                    mode_pend_vld <= 1'b0;
                end
            end
        end
    end

`ifdef CCS_SOFTSTART_EN
    logic        ramp_act;
    logic [20:0] ramp;
    logic [23:0] ramp_tick;
    logic [21:0] ramp_sum;

    assign ramp_act = (state == S_EMIT) && (mode_sel == 2'b11);
    assign ramp_sum = {1'b0, ramp} + 22'(RAMP_STEP);

    always_ff @(posedge clk64_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ramp      <= '0;
            ramp_tick <= '0;
        end else if (!ramp_act) begin
            ramp      <= '0;
            ramp_tick <= '0;
        end else if (duty_sh < ramp) begin
            ramp <= duty_sh;
        end else if (ramp_tick == 24'(RAMP_TICK - 1)) begin
            ramp_tick <= '0;
            ramp      <= (ramp_sum > {1'b0, duty_sh}) ? duty_sh : ramp_sum[20:0];
        end else begin
            ramp_tick <= ramp_tick + 24'd1;
        end
    end

    assign bus.duty_count_o = ramp_act ? ramp : duty_sh;
`else
    assign bus.duty_count_o = duty_sh;
`endif

    assign bus.enable_o         = enable;
    assign bus.ccs_rd_o         = ccs_rd;
    assign bus.state_o          = state;
    assign bus.cfg_ack_o        = ack;
    assign bus.cfg_err_o        = err;
    assign bus.mode_sel_o       = mode_sel;
    assign bus.period_count_o   = period_sh;
    assign bus.fpul_dep_delay_o = fpul_sh;

endmodule

// File: tb/tb_ccs_seq_ctl.sv
// Bench for ccs_seq_ctl with ARM_DLY=16, STOP_DLY=8; config results tracked through an expectation queue.
module tb_ccs_seq_ctl;
    localparam int ARM = 16;
    localparam int STP = 8;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    ccs_seq_ctl_if bus();

    ccs_seq_ctl #(.ARM_DLY(ARM), .STOP_DLY(STP)) dut (
        .clk64_i (clk),
        .rstn_i  (rstn),
        .bus     (bus)
    );

    typedef struct packed {
        logic        ack;
        logic        err;
        logic [1:0]  mode;
        logic [20:0] period;
        logic [20:0] duty;
        logic [7:0]  fpul;
    } cfg_exp_t;

    cfg_exp_t    sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [1:0]  m_mode   = '0;
    logic [20:0] m_period = '0;
    logic [20:0] m_duty   = '0;
    logic [7:0]  m_fpul   = '0;

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cfg_cycle(input logic [1:0] mode, input logic [20:0] period,
                             input logic [20:0] duty, input logic [7:0] fpul, input bit in_idle);
        cfg_exp_t e;
        cfg_exp_t got;
        bit       ok;
        bus.cfg_wr_i     = 1'b1;
        bus.cfg_mode_i   = mode;
        bus.cfg_period_i = period;
        bus.cfg_duty_i   = duty;
        bus.cfg_fpul_i   = fpul;
        ok = (mode == 2'b00) || ((period >= 21'd1280) && (period <= 21'd1280000) && (duty <= period));
        if (ok) begin
            m_period = period;
            m_duty   = duty;
            m_fpul   = fpul;
            if (in_idle) m_mode = mode;
        end
        e = '{ack: ok, err: !ok, mode: m_mode, period: m_period, duty: m_duty, fpul: m_fpul};
        sb.push_back(e);
        step();
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL cfg_scoreboard_empty got none want entry");
        end else begin
            e   = sb.pop_front();
            got = '{ack: bus.cfg_ack_o, err: bus.cfg_err_o, mode: bus.mode_sel_o,
                    period: bus.period_count_o, duty: bus.duty_count_o, fpul: bus.fpul_dep_delay_o};
            if (got !== e) begin
                errors++;
                $display("FAIL cfg_write mode=%0d per=%0d duty=%0d got ack=%0b err=%0b mode=%0d per=%0d duty=%0d fpul=%0d want ack=%0b err=%0b mode=%0d per=%0d duty=%0d fpul=%0d",
                         mode, period, duty, got.ack, got.err, got.mode, got.period, got.duty, got.fpul,
                         e.ack, e.err, e.mode, e.period, e.duty, e.fpul);
            end
        end
    endtask

    task automatic cfg_quiet();
        bus.cfg_wr_i = 1'b0;
        step();
        checks++;
        if ({bus.cfg_ack_o, bus.cfg_err_o} !== 2'b00) begin
            errors++;
            $display("FAIL cfg_pulse_width got ack/err=%b want 00", {bus.cfg_ack_o, bus.cfg_err_o});
        end
    endtask

    task automatic go_emit(input string tag);
        bus.emit_req_i = 1'b1;
        step(ARM + 1);
        checks++;
        if (bus.state_o !== 3'd2) begin
            errors++;
            $display("FAIL %s_enter_emit got state=%0d want 2", tag, bus.state_o);
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({bus.state_o, bus.enable_o, bus.ccs_rd_o, bus.cfg_ack_o, bus.cfg_err_o, bus.mode_sel_o} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl got state=%0d en=%0b rd=%0b ack=%0b err=%0b mode=%0d want all 0",
                     bus.state_o, bus.enable_o, bus.ccs_rd_o, bus.cfg_ack_o, bus.cfg_err_o, bus.mode_sel_o);
        end
        checks++;
        if ({bus.period_count_o, bus.duty_count_o, bus.fpul_dep_delay_o} !== '0) begin
            errors++;
            $display("FAIL reset_data got per=%0d duty=%0d fpul=%0d want 0 0 0",
                     bus.period_count_o, bus.duty_count_o, bus.fpul_dep_delay_o);
        end
        rstn = 1'b1;
        step();
    endtask

    task automatic test_normal();
        bus.emit_req_i = 1'b1;
        step();
        checks++;
        if ({bus.state_o, bus.enable_o, bus.ccs_rd_o} !== {3'd1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL normal_arm got state=%0d en=%0b rd=%0b want 1 1 0", bus.state_o, bus.enable_o, bus.ccs_rd_o);
        end
        for (int i = 1; i < ARM; i++) begin
            step();
            checks++;
            if (bus.ccs_rd_o !== 1'b0) begin
                errors++;
                $display("FAIL normal_rd_early cycle %0d got rd=%0b want 0", i, bus.ccs_rd_o);
            end
        end
        step();
        checks++;
        if ({bus.state_o, bus.enable_o, bus.ccs_rd_o} !== {3'd2, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL normal_emit got state=%0d en=%0b rd=%0b want 2 1 1", bus.state_o, bus.enable_o, bus.ccs_rd_o);
        end
        bus.emit_req_i = 1'b0;
        step();
        checks++;
        if ({bus.state_o, bus.enable_o, bus.ccs_rd_o} !== {3'd3, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL normal_stop got state=%0d en=%0b rd=%0b want 3 1 0", bus.state_o, bus.enable_o, bus.ccs_rd_o);
        end
        for (int i = 1; i < STP; i++) begin
            bus.emit_req_i = (i == 3);
            step();
            checks++;
            if (bus.enable_o !== 1'b1) begin
                errors++;
                $display("FAIL normal_en_early_drop cycle %0d got en=%0b want 1", i, bus.enable_o);
            end
        end
        bus.emit_req_i = 1'b0;
        step();
        checks++;
        if ({bus.state_o, bus.enable_o} !== {3'd0, 1'b0}) begin
            errors++;
            $display("FAIL normal_idle got state=%0d en=%0b want 0 0", bus.state_o, bus.enable_o);
        end
    endtask

    task automatic test_fault();
        go_emit("fault");
        bus.fault_i = 1'b1;
        step();
        checks++;
        if ({bus.state_o, bus.enable_o, bus.ccs_rd_o} !== {3'd4, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL fault_entry got state=%0d en=%0b rd=%0b want 4 0 0", bus.state_o, bus.enable_o, bus.ccs_rd_o);
        end
        bus.emit_req_i  = 1'b0;
        bus.fault_clr_i = 1'b1;
        step();
        bus.fault_clr_i = 1'b0;
        checks++;
        if (bus.state_o !== 3'd4) begin
            errors++;
            $display("FAIL fault_clr_while_faulted got state=%0d want 4", bus.state_o);
        end
        bus.fault_i     = 1'b0;
        bus.emit_req_i  = 1'b1;
        bus.fault_clr_i = 1'b1;
        step();
        bus.fault_clr_i = 1'b0;
        step();
        checks++;
        if (bus.state_o !== 3'd4) begin
            errors++;
            $display("FAIL fault_clr_with_req got state=%0d want 4", bus.state_o);
        end
        bus.emit_req_i  = 1'b0;
        bus.fault_clr_i = 1'b1;
        step();
        bus.fault_clr_i = 1'b0;
        checks++;
        if ({bus.state_o, bus.enable_o} !== {3'd0, 1'b0}) begin
            errors++;
            $display("FAIL fault_clear got state=%0d en=%0b want 0 0", bus.state_o, bus.enable_o);
        end
    endtask

    task automatic test_interlock();
        bus.emit_req_i = 1'b1;
        step(3);
        bus.interlock_ok_i = 1'b0;
        step();
        checks++;
        if ({bus.state_o, bus.enable_o, bus.ccs_rd_o} !== {3'd4, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL interlock_loss_arm got state=%0d en=%0b want 4 0", bus.state_o, bus.enable_o);
        end
        bus.interlock_ok_i = 1'b1;
        bus.emit_req_i     = 1'b0;
        bus.fault_clr_i    = 1'b1;
        step();
        bus.fault_clr_i = 1'b0;
        checks++;
        if (bus.state_o !== 3'd0) begin
            errors++;
            $display("FAIL interlock_clear got state=%0d want 0", bus.state_o);
        end
    endtask

    task automatic test_config();
        cfg_cycle(2'b11, 21'd1000,    21'd500,   8'd3,  1'b1);
        cfg_quiet();
        cfg_cycle(2'b11, 21'd12800,   21'd6400,  8'd5,  1'b1);
        cfg_quiet();
        cfg_cycle(2'b11, 21'd12800,   21'd20000, 8'd7,  1'b1);
        cfg_quiet();
        cfg_cycle(2'b01, 21'd1279,    21'd100,   8'd9,  1'b1);
        cfg_quiet();
        cfg_cycle(2'b10, 21'd1280,    21'd1280,  8'd11, 1'b1);
        cfg_quiet();
        cfg_cycle(2'b01, 21'd1280001, 21'd10,    8'd13, 1'b1);
        cfg_quiet();
    endtask

    task automatic test_back_to_back();
        cfg_cycle(2'b01, 21'd1280000, 21'd640000, 8'd21, 1'b1);
        cfg_cycle(2'b00, 21'd5,       21'd99,     8'd22, 1'b1);
        cfg_cycle(2'b11, 21'd50,      21'd10,     8'd23, 1'b1);
        cfg_cycle(2'b11, 21'd2560,    21'd0,      8'd24, 1'b1);
        cfg_quiet();
    endtask

    task automatic test_mode_defer();
        cfg_cycle(2'b00, 21'd12800, 21'd6400, 8'd1, 1'b1);
        cfg_quiet();
        go_emit("defer");
        cfg_cycle(2'b01, 21'd25600, 21'd3200, 8'd2, 1'b0);
        cfg_quiet();
        bus.emit_req_i = 1'b0;
        step();
        for (int i = 0; i < STP - 1; i++) begin
            step();
            checks++;
            if ({bus.state_o, bus.mode_sel_o} !== {3'd3, 2'b00}) begin
                errors++;
                $display("FAIL defer_held cycle %0d got state=%0d mode=%0d want 3 0", i, bus.state_o, bus.mode_sel_o);
            end
        end
        step();
        m_mode = 2'b01;
        checks++;
        if ({bus.state_o, bus.mode_sel_o} !== {3'd0, 2'b01}) begin
            errors++;
            $display("FAIL defer_applied got state=%0d mode=%0d want 0 1", bus.state_o, bus.mode_sel_o);
        end
    endtask

    task automatic test_abort_arm();
        bit seen_rd = 1'b0;
        bus.emit_req_i = 1'b1;
        step(5);
        seen_rd = bus.ccs_rd_o;
        bus.emit_req_i = 1'b0;
        step();
        checks++;
        if ({bus.state_o, bus.enable_o} !== {3'd0, 1'b0}) begin
            errors++;
            $display("FAIL abort_idle got state=%0d en=%0b want 0 0", bus.state_o, bus.enable_o);
        end
        for (int i = 0; i < 2 * ARM; i++) begin
            step();
            seen_rd = seen_rd | bus.ccs_rd_o;
        end
        checks++;
        if (seen_rd !== 1'b0) begin
            errors++;
            $display("FAIL abort_rd_seen got %0b want 0", seen_rd);
        end
    endtask

    task automatic test_duty_ramp();
        logic [20:0] prev;
        logic [20:0] want;
        cfg_cycle(2'b11, 21'd12800, 21'd200, 8'd4, 1'b1);
        cfg_quiet();
        go_emit("ramp");
`ifdef CCS_SOFTSTART_EN
        checks++;
        if (bus.duty_count_o !== 21'd0) begin
            errors++;
            $display("FAIL ramp_start got %0d want 0", bus.duty_count_o);
        end
        prev = 21'd0;
        for (int k = 1; k <= 4; k++) begin
            want = (k * 64 > 200) ? 21'd200 : 21'(k * 64);
            step(639);
            checks++;
            if (bus.duty_count_o !== prev) begin
                errors++;
                $display("FAIL ramp_hold step %0d got %0d want %0d", k, bus.duty_count_o, prev);
            end
            step();
            checks++;
            if (bus.duty_count_o !== want) begin
                errors++;
                $display("FAIL ramp_step %0d got %0d want %0d", k, bus.duty_count_o, want);
            end
            prev = want;
        end
`else
        prev = 21'd200;
        want = 21'd200;
        checks++;
        if (bus.duty_count_o !== prev) begin
            errors++;
            $display("FAIL duty_passthrough_entry got %0d want %0d", bus.duty_count_o, prev);
        end
        step(700);
        checks++;
        if (bus.duty_count_o !== want) begin
            errors++;
            $display("FAIL duty_passthrough_late got %0d want %0d", bus.duty_count_o, want);
        end
`endif
        bus.emit_req_i = 1'b0;
        step();
        checks++;
        if (bus.duty_count_o !== 21'd200) begin
            errors++;
            $display("FAIL ramp_stop_duty got %0d want 200", bus.duty_count_o);
        end
        step(STP);
    endtask

    task automatic test_async_reset();
        go_emit("areset");
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if ({bus.state_o, bus.enable_o, bus.ccs_rd_o, bus.mode_sel_o, bus.period_count_o} !== '0) begin
            errors++;
            $display("FAIL async_reset got state=%0d en=%0b rd=%0b mode=%0d per=%0d want all 0",
                     bus.state_o, bus.enable_o, bus.ccs_rd_o, bus.mode_sel_o, bus.period_count_o);
        end
        #2;
        rstn = 1'b1;
        bus.emit_req_i = 1'b0;
        step(2);
        checks++;
        if ({bus.state_o, bus.enable_o} !== {3'd0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset_release got state=%0d en=%0b want 0 0", bus.state_o, bus.enable_o);
        end
    endtask

    initial begin
        bus.cfg_wr_i       = 1'b0;
        bus.cfg_mode_i     = '0;
        bus.cfg_period_i   = '0;
        bus.cfg_duty_i     = '0;
        bus.cfg_fpul_i     = '0;
        bus.emit_req_i     = 1'b0;
        bus.interlock_ok_i = 1'b1;
        bus.fault_i        = 1'b0;
        bus.fault_clr_i    = 1'b0;
        test_reset();
        test_normal();
        test_fault();
        test_interlock();
        test_config();
        test_back_to_back();
        test_mode_defer();
        test_abort_arm();
        test_duty_ramp();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
